// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake: single-cycle logic/arithmetic/shift ops
// and a WIDTH-cycle shift-add multiplier. Result and Z/N/V flags update only with done.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       ALUop,
   input  logic [WIDTH-1:0] Ain,
   input  logic [WIDTH-1:0] Bin,
   output logic [WIDTH-1:0] out,
   output logic             Z,
   output logic             N,
   output logic             V,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_LSL = 3'b101;
   localparam logic [2:0] OP_LSR = 3'b110;
   localparam logic [2:0] OP_ASR = 3'b111;

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] acc_reg, mcand_reg, mplier_reg, out_reg;
   logic             z_reg, n_reg, v_reg, done_reg;

   logic             issue_op, issue_mul, finish_mul, last_iter;
   logic [WIDTH-1:0] alu_r, lsr_r, asr_r, acc_step;
   logic             alu_v;

   // Right shifts built bit by bit; only the fill bit differs between lsr and asr.
   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shr
         assign lsr_r[gi] = Ain[gi+1];
         assign asr_r[gi] = Ain[gi+1];
      end
   endgenerate
   assign lsr_r[WIDTH-1] = 1'b0;
   assign asr_r[WIDTH-1] = Ain[WIDTH-1];

   always_comb begin
      alu_r = '0;
      alu_v = 1'b0;
      case (ALUop)
         OP_ADD: begin
            alu_r = Ain + Bin;
            alu_v = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (alu_r[WIDTH-1] != Ain[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r = Ain - Bin;
            alu_v = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (alu_r[WIDTH-1] != Ain[WIDTH-1]);
         end
         OP_AND:  alu_r = Ain & Bin;
         OP_NOT:  alu_r = ~Bin;
         OP_LSL:  alu_r = {Ain[WIDTH-2:0], 1'b0};
         OP_LSR:  alu_r = lsr_r;
         OP_ASR:  alu_r = asr_r;
         default: alu_r = '0;
      endcase
   end

   assign last_iter = (cnt_reg == CW'(WIDTH - 1));
   assign acc_step  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start && ALUop == OP_MUL) state_next = MUL;
         MUL:     if (last_iter) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      issue_op   = (state_reg == IDLE) && start && (ALUop != OP_MUL);
      issue_mul  = (state_reg == IDLE) && start && (ALUop == OP_MUL);
      finish_mul = (state_reg == MUL) && last_iter;
      busy       = (state_reg == MUL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_reg    <= '0;
         z_reg      <= 1'b0;
         n_reg      <= 1'b0;
         v_reg      <= 1'b0;
         done_reg   <= 1'b0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         done_reg <= issue_op || finish_mul;
         if (issue_op) begin
            out_reg <= alu_r;
            z_reg   <= (alu_r == '0);
            n_reg   <= alu_r[WIDTH-1];
            v_reg   <= alu_v;
         end
         if (issue_mul) begin
            mcand_reg  <= Ain;
            mplier_reg <= Bin;
            acc_reg    <= '0;
            cnt_reg    <= '0;
         end
         if (state_reg == MUL) begin
            acc_reg    <= acc_step;
            mcand_reg  <= {mcand_reg[WIDTH-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
            cnt_reg    <= cnt_reg + 1'b1;
         end
         // Final iteration's partial sum goes straight to the result; products wrap silently.
         if (finish_mul) begin
            out_reg <= acc_step;
            z_reg   <= (acc_step == '0);
            n_reg   <= acc_step[WIDTH-1];
            v_reg   <= 1'b0;
         end
      end
   end

   assign out  = out_reg;
   assign Z    = z_reg;
   assign N    = n_reg;
   assign V    = v_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a negedge monitor
// pops and compares them (value, flags and arrival cycle) whenever done is seen.
module tb_alu_seq;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [2:0]   ALUop;
   logic [W-1:0] Ain, Bin, out;
   logic         Z, N, V, busy, done;

   typedef struct {
      logic [W-1:0] r;
      logic         z, n, v;
      int           due;
   } exp_t;

   exp_t q[$];
   exp_t last_e;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .ALUop(ALUop),
      .Ain(Ain), .Bin(Bin), .out(out), .Z(Z), .N(N), .V(V),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic on unsigned/signed interpretations.
   function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
      exp_t   e;
      longint m    = longint'(1) << W;
      longint half = m / 2;
      longint ua   = longint'(a);
      longint ub   = longint'(b);
      longint sa   = (ua >= half) ? ua - m : ua;
      longint sb   = (ub >= half) ? ub - m : ub;
      longint r    = 0;
      longint s;
      e.v = 1'b0;
      case (op)
         3'd0: begin r = ua + ub; s = sa + sb; e.v = (s >= half) || (s < -half); end
         3'd1: begin r = ua - ub; s = sa - sb; e.v = (s >= half) || (s < -half); end
         3'd2: r = ua & ub;
         3'd3: r = m - 1 - ub;
         3'd4: r = ua * ub;
         3'd5: r = ua * 2;
         3'd6: r = ua / 2;
         default: r = sa >>> 1;
      endcase
      r     = ((r % m) + m) % m;
      e.r   = W'(r);
      e.z   = (r == 0);
      e.n   = (r >= half);
      e.due = 0;
      return e;
   endfunction

   // Monitor: every done must match the oldest outstanding expectation, on time.
   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'(0));
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", 32'({out, Z, N, V}), 32'({e.r, e.z, e.n, e.v}));
            chk("done_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic wait_mul();
      int n = 0;
      while (busy && n < 4 * W) begin
         n++;
         // Garbage on the request inputs while busy must be ignored.
         start = 1'($urandom);
         ALUop = 3'($urandom);
         Ain   = W'($urandom);
         Bin   = W'($urandom);
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("mul_busy_cycles", 32'(n), 32'(W));
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e     = ref_model(op, a, b);
      e.due = cyc + 1 + ((op == 3'd4) ? W : 0);
      q.push_back(e);
      last_e = e;
      ALUop  = op;
      Ain    = a;
      Bin    = b;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (op == 3'd4) wait_mul();
   endtask

   task automatic hold5();
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold", 32'({out, Z, N, V}), 32'({last_e.r, last_e.z, last_e.n, last_e.v}));
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 4))
         0:       return W'(16'h7FFF);
         1:       return W'(16'h8000);
         2:       return W'($urandom_range(0, 3));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      start = 1'b1;
      ALUop = 3'd0;
      Ain   = W'(1);
      Bin   = W'(1);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", 32'(out), 32'(0));
      chk("reset_flags", 32'({Z, N, V}), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_done", 32'(done), 32'(0));
      start = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      issue(3'd0, 16'h0002, 16'h0004);
      issue(3'd1, 16'h0004, 16'h0002);
      issue(3'd2, 16'h0004, 16'h0004);
      issue(3'd3, 16'h0000, 16'h0004);
      issue(3'd1, 16'h0002, 16'h0002);
      issue(3'd0, 16'h7FFF, 16'h0001);
      issue(3'd1, 16'h8000, 16'h0001);
      issue(3'd7, 16'h8002, 16'h0000);
      issue(3'd6, 16'h8002, 16'h0000);
      issue(3'd5, 16'h8001, 16'h0000);
      issue(3'd4, 16'h0003, 16'h0005);
      hold5();
      issue(3'd4, 16'h0100, 16'h0100);
      hold5();
      issue(3'd4, 16'h1234, 16'h0000);

      // Abort a multiply with reset on its 7th cycle: no done, outputs cleared.
      ALUop = 3'd4;
      Ain   = W'(3);
      Bin   = W'(5);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("busy_before_abort", 32'(busy), 32'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_out", 32'({out, Z, N, V}), 32'(0));
      issue(3'd0, 16'h0001, 16'h0001);

      for (int i = 0; i < 200; i++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         issue(op, pick(), pick());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 32'(q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
